// File: rtl/noc_xbar_switch_pkg.sv
// Shared definitions for the NoC crossbar switch: default widths, port index
// map of the 3-in/2-out router, per-output FSM encoding and a width helper.
package noc_xbar_switch_pkg;

  localparam int DATA_W_DEF = 8;

  // Input port map of the default router instance
  localparam int PORT_VC0 = 0;
  localparam int PORT_VC1 = 1;
  localparam int PORT_NI  = 2;

  // Output port map of the default router instance
  localparam int OUT_DOWN = 0;
  localparam int OUT_NI   = 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } xbar_state_e;

  // Index width for n entries, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_xbar_switch_if.sv
// Flit bus of the crossbar: NUM_IN flat input lanes and NUM_OUT flat output
// lanes. The switch uses the slave modport, its environment the master one.
interface noc_xbar_switch_if
  import noc_xbar_switch_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_IN  = 3,
  parameter int NUM_OUT = 2,
  parameter int DEST_W  = idx_width(NUM_OUT)
);

  logic [NUM_IN-1:0]          in_valid;
  logic [NUM_IN*DATA_W-1:0]   in_data;
  logic [NUM_IN-1:0]          in_head;
  logic [NUM_IN-1:0]          in_tail;
  logic [NUM_IN*DEST_W-1:0]   in_dest;
  logic [NUM_IN-1:0]          in_ready;
  logic [NUM_OUT-1:0]         out_valid;
  logic [NUM_OUT*DATA_W-1:0]  out_data;
  logic [NUM_OUT-1:0]         out_tail;
  logic [NUM_OUT-1:0]         out_ready;

  modport master (
    output in_valid, in_data, in_head, in_tail, in_dest, out_ready,
    input  in_ready, out_valid, out_data, out_tail
  );

  modport slave (
    input  in_valid, in_data, in_head, in_tail, in_dest, out_ready,
    output in_ready, out_valid, out_data, out_tail
  );

endinterface

// File: rtl/noc_xbar_switch_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request found scanning
// upward from the pointer; the pointer moves past the winner only when the
// grant is actually used (en).
module noc_rr_arbiter
  import noc_xbar_switch_pkg::*;
#(
  parameter int N     = 3,
  parameter int PTR_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] scan_idx_s;

  // Scan requests starting at the pointer and pick the first one found
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    any        = 1'b0;
    scan_idx_s = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx_s = PTR_W'((int'(ptr_r) + k) % N);
      if (!any && req[scan_idx_s]) begin
        any               = 1'b1;
        grant[scan_idx_s] = 1'b1;
        grant_idx         = scan_idx_s;
      end else begin
        any = any;
      end
    end
  end

  // Advance the pointer to the entry after the winner when the grant is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (en) begin
      ptr_r <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/noc_xbar_switch.sv
// Wormhole crossbar NUM_IN x NUM_OUT. Each output arbitrates head flits
// round-robin, then stays locked to the winning input until its tail flit.
// Outputs are registered valid/ready stages sustaining one flit per cycle.
// Optional macro SWITCH_STATS_EN adds per-output flit and stall counters.
module noc_xbar_switch
  import noc_xbar_switch_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_IN  = 3,
  parameter int NUM_OUT = 2,
  parameter int DEST_W  = idx_width(NUM_OUT)
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef SWITCH_STATS_EN
  output logic [NUM_OUT*16-1:0] stat_flits,
  output logic [NUM_OUT*16-1:0] stat_stall,
`endif
  noc_xbar_switch_if.slave     bus
);

  localparam int IDX_W = idx_width(NUM_IN);

  xbar_state_e             state_r     [NUM_OUT];
  xbar_state_e             state_nxt_s [NUM_OUT];
  logic [IDX_W-1:0]        owner_r     [NUM_OUT];
  logic [IDX_W-1:0]        owner_nxt_s [NUM_OUT];
  logic [NUM_IN-1:0]       req_s       [NUM_OUT];
  logic [NUM_IN-1:0]       arb_grant_s [NUM_OUT];
  logic [IDX_W-1:0]        arb_idx_s   [NUM_OUT];
  logic                    arb_any_s   [NUM_OUT];
  logic [NUM_IN-1:0]       grant_s     [NUM_OUT];
  logic [IDX_W-1:0]        sel_idx_s   [NUM_OUT];
  logic [NUM_OUT-1:0]      arb_en_s;
  logic [NUM_OUT-1:0]      space_s;
  logic [NUM_OUT-1:0]      load_s;
  logic [NUM_IN-1:0]       owns_s;
  logic [NUM_IN-1:0]       in_ready_s;
  logic [NUM_OUT-1:0]      out_valid_r;
  logic [NUM_OUT-1:0]      out_tail_r;
  logic [NUM_OUT*DATA_W-1:0] out_data_r;

  // Head requests per output; inputs that own a locked output are masked so
  // that an input is never granted by two outputs
  always_comb begin
    owns_s = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      if (state_r[o] == ST_LOCKED) begin
        owns_s[owner_r[o]] = 1'b1;
      end else begin
        owns_s = owns_s;
      end
    end
    for (int o = 0; o < NUM_OUT; o++) begin
      req_s[o] = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        req_s[o][i] = bus.in_valid[i] & bus.in_head[i] & ~owns_s[i] &
                      (bus.in_dest[i*DEST_W +: DEST_W] == DEST_W'(o));
      end
    end
  end

  for (genvar o = 0; o < NUM_OUT; o++) begin : g_arb
    noc_rr_arbiter #(
      .N     (NUM_IN),
      .PTR_W (IDX_W)
    ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_s[o]),
      .en        (arb_en_s[o]),
      .grant     (arb_grant_s[o]),
      .grant_idx (arb_idx_s[o]),
      .any       (arb_any_s[o])
    );
  end

  // Per-output FSM: grant, flit select and next lock state
  always_comb begin
    in_ready_s = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      state_nxt_s[o] = state_r[o];
      owner_nxt_s[o] = owner_r[o];
      grant_s[o]     = '0;
      arb_en_s[o]    = 1'b0;
      sel_idx_s[o]   = owner_r[o];
      space_s[o]     = ~out_valid_r[o] | bus.out_ready[o];
      if (rst) begin
        state_nxt_s[o] = ST_IDLE;
      end else begin
        case (state_r[o])
          ST_IDLE: begin
            if (space_s[o] && arb_any_s[o]) begin
              grant_s[o]   = arb_grant_s[o];
              arb_en_s[o]  = 1'b1;
              sel_idx_s[o] = arb_idx_s[o];
              if (!bus.in_tail[arb_idx_s[o]]) begin
                state_nxt_s[o] = ST_LOCKED;
                owner_nxt_s[o] = arb_idx_s[o];
              end else begin
                state_nxt_s[o] = ST_IDLE;
              end
            end else begin
              state_nxt_s[o] = ST_IDLE;
            end
          end
          ST_LOCKED: begin
            if (space_s[o] && bus.in_valid[owner_r[o]] && !bus.in_head[owner_r[o]]) begin
              grant_s[o][owner_r[o]] = 1'b1;
              if (bus.in_tail[owner_r[o]]) begin
                state_nxt_s[o] = ST_IDLE;
              end else begin
                state_nxt_s[o] = ST_LOCKED;
              end
            end else begin
              state_nxt_s[o] = ST_LOCKED;
            end
          end
          default: begin
            state_nxt_s[o] = ST_IDLE;
          end
        endcase
      end
      load_s[o]  = |grant_s[o];
      in_ready_s = in_ready_s | grant_s[o];
    end
  end

  // Lock state and output registers; a loaded flit replaces the held one,
  // otherwise the held flit leaves when downstream is ready
  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_OUT; o++) begin
      if (rst) begin
        state_r[o]                      <= ST_IDLE;
        owner_r[o]                      <= '0;
        out_valid_r[o]                  <= 1'b0;
        out_tail_r[o]                   <= 1'b0;
        out_data_r[o*DATA_W +: DATA_W]  <= '0;
      end else begin
        state_r[o] <= state_nxt_s[o];
        owner_r[o] <= owner_nxt_s[o];
        if (load_s[o]) begin
          out_valid_r[o]                 <= 1'b1;
          out_tail_r[o]                  <= bus.in_tail[sel_idx_s[o]];
          out_data_r[o*DATA_W +: DATA_W] <= bus.in_data[int'(sel_idx_s[o])*DATA_W +: DATA_W];
        end else if (bus.out_ready[o]) begin
          out_valid_r[o] <= 1'b0;
        end else begin
          out_valid_r[o] <= out_valid_r[o];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_tail  = out_tail_r;

`ifdef SWITCH_STATS_EN
  logic [NUM_OUT*16-1:0] stat_flits_r;
  logic [NUM_OUT*16-1:0] stat_stall_r;

  // Count accepted flits and backpressured cycles per output, wrapping at 2^16
  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_OUT; o++) begin
      if (rst) begin
        stat_flits_r[o*16 +: 16] <= 16'd0;
        stat_stall_r[o*16 +: 16] <= 16'd0;
      end else begin
        if (load_s[o]) begin
          stat_flits_r[o*16 +: 16] <= stat_flits_r[o*16 +: 16] + 16'd1;
        end else begin
          stat_flits_r[o*16 +: 16] <= stat_flits_r[o*16 +: 16];
        end
        if (out_valid_r[o] && !bus.out_ready[o]) begin
          stat_stall_r[o*16 +: 16] <= stat_stall_r[o*16 +: 16] + 16'd1;
        end else begin
          stat_stall_r[o*16 +: 16] <= stat_stall_r[o*16 +: 16];
        end
      end
    end
  end

  assign stat_flits = stat_flits_r;
  assign stat_stall = stat_stall_r;
`endif

endmodule

// File: tb/tb_noc_xbar_switch.sv
// Directed bench for the 3x2 crossbar: reset, single flit, round-robin
// contention, backpressure, parallel streams with mid-packet reset, and the
// optional statistics counters when SWITCH_STATS_EN is defined.
module tb_noc_xbar_switch;

  localparam int DATA_W  = 8;
  localparam int NUM_IN  = 3;
  localparam int NUM_OUT = 2;
  localparam int DEST_W  = 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  noc_xbar_switch_if #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DEST_W(DEST_W)) bus ();

`ifdef SWITCH_STATS_EN
  logic [NUM_OUT*16-1:0] stat_flits;
  logic [NUM_OUT*16-1:0] stat_stall;
`endif

  noc_xbar_switch #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DEST_W(DEST_W)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef SWITCH_STATS_EN
    .stat_flits (stat_flits),
    .stat_stall (stat_stall),
`endif
    .bus        (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flit(input int i, input logic [7:0] d, input logic h, input logic t, input logic dst);
    bus.in_valid[i]        = 1'b1;
    bus.in_data[i*8 +: 8]  = d;
    bus.in_head[i]         = h;
    bus.in_tail[i]         = t;
    bus.in_dest[i]         = dst;
  endtask

  task automatic clr(input int i);
    bus.in_valid[i] = 1'b0;
    bus.in_head[i]  = 1'b0;
    bus.in_tail[i]  = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.out_ready = 2'b11;
    bus.in_valid  = 3'b111;
    bus.in_head   = 3'b111;
    bus.in_tail   = 3'b111;
    bus.in_dest   = 3'b000;
    bus.in_data   = 24'h33_22_11;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid: got %b expected %b", bus.out_valid, 2'b00); end
      checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h expected %h", bus.out_data, 16'h0000); end
      checks++; if (bus.in_ready !== 3'b000) begin errors++; $display("FAIL reset_in_ready: got %b expected %b", bus.in_ready, 3'b000); end
    end
    rst = 1'b0;
    clr(0); clr(1); clr(2);
  endtask

  task automatic test_single_flit();
    set_flit(0, 8'hA5, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 3'b001) begin errors++; $display("FAIL single_ready: got %b expected %b", bus.in_ready, 3'b001); end
    tick();
    checks++; if (bus.out_valid[0] !== 1'b1 || bus.out_data[7:0] !== 8'hA5 || bus.out_tail[0] !== 1'b1) begin errors++; $display("FAIL single_out: got v=%b d=%h t=%b expected v=1 d=a5 t=1", bus.out_valid[0], bus.out_data[7:0], bus.out_tail[0]); end
    checks++; if (bus.out_valid[1] !== 1'b0) begin errors++; $display("FAIL single_other_out: got %b expected %b", bus.out_valid[1], 1'b0); end
    clr(0);
    set_flit(1, 8'h3C, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 3'b010) begin errors++; $display("FAIL single_stays_idle: got %b expected %b", bus.in_ready, 3'b010); end
    tick();
    checks++; if (bus.out_data[7:0] !== 8'h3C) begin errors++; $display("FAIL single_second: got %h expected %h", bus.out_data[7:0], 8'h3C); end
    clr(1);
  endtask

  task automatic test_rr_contention();
    set_flit(0, 8'h11, 1'b1, 1'b0, 1'b0);
    set_flit(1, 8'h21, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 3'b001) begin errors++; $display("FAIL rr_first_grant: got %b expected %b", bus.in_ready, 3'b001); end
    tick();
    checks++; if (bus.out_data[7:0] !== 8'h11) begin errors++; $display("FAIL rr_flit0: got %h expected %h", bus.out_data[7:0], 8'h11); end
    set_flit(0, 8'h12, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 3'b001) begin errors++; $display("FAIL rr_lock_body: got %b expected %b", bus.in_ready, 3'b001); end
    tick();
    checks++; if (bus.out_data[7:0] !== 8'h12 || bus.out_tail[0] !== 1'b0) begin errors++; $display("FAIL rr_flit1: got %h/%b expected 12/0", bus.out_data[7:0], bus.out_tail[0]); end
    set_flit(0, 8'h13, 1'b0, 1'b1, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 3'b001) begin errors++; $display("FAIL rr_lock_tail: got %b expected %b", bus.in_ready, 3'b001); end
    tick();
    checks++; if (bus.out_data[7:0] !== 8'h13 || bus.out_tail[0] !== 1'b1) begin errors++; $display("FAIL rr_flit2: got %h/%b expected 13/1", bus.out_data[7:0], bus.out_tail[0]); end
    clr(0);
    #1;
    checks++; if (bus.in_ready !== 3'b010) begin errors++; $display("FAIL rr_second_pkt: got %b expected %b", bus.in_ready, 3'b010); end
    tick();
    checks++; if (bus.out_data[7:0] !== 8'h21) begin errors++; $display("FAIL rr_in1_flit0: got %h expected %h", bus.out_data[7:0], 8'h21); end
    set_flit(1, 8'h22, 1'b0, 1'b0, 1'b0);
    tick();
    set_flit(1, 8'h23, 1'b0, 1'b1, 1'b0);
    tick();
    checks++; if (bus.out_data[7:0] !== 8'h23 || bus.out_tail[0] !== 1'b1) begin errors++; $display("FAIL rr_in1_tail: got %h/%b expected 23/1", bus.out_data[7:0], bus.out_tail[0]); end
    clr(1);
    set_flit(0, 8'h40, 1'b1, 1'b1, 1'b0);
    set_flit(1, 8'h41, 1'b1, 1'b1, 1'b0);
    set_flit(2, 8'h42, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 3'b100) begin errors++; $display("FAIL rr_fair_in2: got %b expected %b", bus.in_ready, 3'b100); end
    tick();
    checks++; if (bus.out_data[7:0] !== 8'h42) begin errors++; $display("FAIL rr_fair_d2: got %h expected %h", bus.out_data[7:0], 8'h42); end
    clr(2);
    #1;
    checks++; if (bus.in_ready !== 3'b001) begin errors++; $display("FAIL rr_fair_in0: got %b expected %b", bus.in_ready, 3'b001); end
    tick();
    clr(0);
    #1;
    checks++; if (bus.in_ready !== 3'b010) begin errors++; $display("FAIL rr_fair_in1: got %b expected %b", bus.in_ready, 3'b010); end
    tick();
    checks++; if (bus.out_data[7:0] !== 8'h41) begin errors++; $display("FAIL rr_fair_d1: got %h expected %h", bus.out_data[7:0], 8'h41); end
    clr(1);
  endtask

  task automatic test_backpressure();
    set_flit(1, 8'h51, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 3'b010) begin errors++; $display("FAIL bp_head: got %b expected %b", bus.in_ready, 3'b010); end
    tick();
    set_flit(1, 8'h59, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 3'b000) begin errors++; $display("FAIL bp_head_while_locked: got %b expected %b", bus.in_ready, 3'b000); end
    tick();
    checks++; if (bus.out_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected %b", bus.out_valid[0], 1'b0); end
    set_flit(1, 8'h52, 1'b0, 1'b0, 1'b0);
    tick();
    bus.out_ready[0] = 1'b0;
    set_flit(1, 8'h53, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.in_ready !== 3'b000) begin errors++; $display("FAIL bp_stall_ready: got %b expected %b", bus.in_ready, 3'b000); end
      tick();
      checks++; if (bus.out_valid[0] !== 1'b1 || bus.out_data[7:0] !== 8'h52) begin errors++; $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=52", bus.out_valid[0], bus.out_data[7:0]); end
    end
    bus.out_ready[0] = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 3'b010) begin errors++; $display("FAIL bp_resume: got %b expected %b", bus.in_ready, 3'b010); end
    tick();
    checks++; if (bus.out_data[7:0] !== 8'h53) begin errors++; $display("FAIL bp_next: got %h expected %h", bus.out_data[7:0], 8'h53); end
    set_flit(1, 8'h54, 1'b0, 1'b1, 1'b0);
    tick();
    checks++; if (bus.out_data[7:0] !== 8'h54 || bus.out_tail[0] !== 1'b1) begin errors++; $display("FAIL bp_tail: got %h/%b expected 54/1", bus.out_data[7:0], bus.out_tail[0]); end
    clr(1);
    tick();
    checks++; if (bus.out_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected %b", bus.out_valid[0], 1'b0); end
  endtask

  task automatic test_parallel_reset();
    set_flit(0, 8'h60, 1'b1, 1'b0, 1'b0);
    set_flit(2, 8'h70, 1'b1, 1'b0, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 3'b101) begin errors++; $display("FAIL par_heads: got %b expected %b", bus.in_ready, 3'b101); end
    tick();
    checks++; if (bus.out_data !== 16'h7060 || bus.out_valid !== 2'b11) begin errors++; $display("FAIL par_flit0: got %h/%b expected 7060/11", bus.out_data, bus.out_valid); end
    set_flit(0, 8'h61, 1'b0, 1'b0, 1'b0);
    set_flit(2, 8'h71, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if (bus.out_data !== 16'h7161) begin errors++; $display("FAIL par_flit1: got %h expected %h", bus.out_data, 16'h7161); end
    rst = 1'b1;
    set_flit(0, 8'h62, 1'b0, 1'b0, 1'b0);
    set_flit(2, 8'h72, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 3'b000) begin errors++; $display("FAIL par_rst_ready: got %b expected %b", bus.in_ready, 3'b000); end
    tick();
    checks++; if (bus.out_valid !== 2'b00 || bus.out_data !== 16'h0000) begin errors++; $display("FAIL par_rst_clear: got %b/%h expected 00/0000", bus.out_valid, bus.out_data); end
    rst = 1'b0;
    set_flit(0, 8'h80, 1'b1, 1'b1, 1'b0);
    set_flit(2, 8'h73, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 3'b001) begin errors++; $display("FAIL par_after_rst: got %b expected %b", bus.in_ready, 3'b001); end
    tick();
    checks++; if (bus.out_valid !== 2'b01 || bus.out_data[7:0] !== 8'h80) begin errors++; $display("FAIL par_new_head: got %b/%h expected 01/80", bus.out_valid, bus.out_data[7:0]); end
    clr(0); clr(2);
  endtask

`ifdef SWITCH_STATS_EN
  task automatic test_stats();
    for (int k = 0; k < 10; k++) begin
      set_flit(1, 8'(8'h90 + k), (k == 0), (k == 9), 1'b1);
      if (k == 3) begin
        bus.out_ready[1] = 1'b0;
        for (int s = 0; s < 3; s++) tick();
        bus.out_ready[1] = 1'b1;
      end
      tick();
    end
    checks++; if (bus.out_data[15:8] !== 8'h99 || bus.out_tail[1] !== 1'b1) begin errors++; $display("FAIL stats_last: got %h/%b expected 99/1", bus.out_data[15:8], bus.out_tail[1]); end
    clr(1);
    tick();
    checks++; if (stat_flits[31:16] !== 16'd10) begin errors++; $display("FAIL stats_flits1: got %0d expected %0d", stat_flits[31:16], 10); end
    checks++; if (stat_stall[31:16] !== 16'd3) begin errors++; $display("FAIL stats_stall1: got %0d expected %0d", stat_stall[31:16], 3); end
    checks++; if (stat_flits[15:0] !== 16'd1 || stat_stall[15:0] !== 16'd0) begin errors++; $display("FAIL stats_out0: got %0d/%0d expected 1/0", stat_flits[15:0], stat_stall[15:0]); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.in_head   = '0;
    bus.in_tail   = '0;
    bus.in_dest   = '0;
    bus.out_ready = '1;
    test_reset();
    test_single_flit();
    test_rr_contention();
    test_backpressure();
    test_parallel_reset();
`ifdef SWITCH_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
